mem_arb2: RTL and testbench
===========================

Name: mem_arb2

Overview:
- Two-requester round-robin arbiter and sequencer that shares one mem_ctl_io instance.
- Each requester sees a private valid/ack request channel and read-return channel.
- The block serialises transactions: it grants one requester, latches its command, runs the 4-phase din handshake and, for reads, the 4-phase dout handshake, then releases.
- A watchdog aborts reads whose data never returns.

Parameters:
AW  8  address width
DW  8  data width
TMO  64  watchdog limit in clk cycles for read-data return; minimum 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
rq_din_valid  in  2  per-requester request valid, bit i = requester i
rq_wen  in  2  per-requester 1=write, 0=read
rq_addr  in  2*AW  per-requester address, slice i
rq_wdata  in  2*DW  per-requester write data, slice i
rq_din_ack  out  2  per-requester request acknowledge
rq_dout_valid  out  2  per-requester read data valid
rq_dout_ack  in  2  per-requester read data acknowledge
rq_rdata  out  DW  read data, shared, qualified by rq_dout_valid
rq_err  out  2  one-cycle pulse: watchdog abort of requester i's read
din_valid  out  1  to mem_ctl_io
wen  out  1  to mem_ctl_io
addr  out  AW  to memory
wdata  out  DW  to memory
din_ack  in  1  from mem_ctl_io
dout_valid  in  1  from mem_ctl_io
rdata  in  DW  from memory
dout_ack  out  1  to mem_ctl_io
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, last=1 (requester 0 wins the first tie), timer=0. All outputs are 0.
- All handshakes are 4-phase: valid rises, ack rises, valid falls, ack falls.
- IDLE:
  - If any rq_din_valid bit is set, grant gnt. A single requester is granted directly. On a tie, gnt = ~last.
  - On the grant edge, latch wen/addr/wdata from slice gnt, set last<=gnt, and go to REQ.
  - Grant-to-din_valid latency is 1 cycle.
- REQ: din_valid=1. When din_ack=1, rq_din_ack[gnt]=1 and go to REL.
- REL:
  - din_valid=0, and rq_din_ack[gnt] stays 1.
  - Leave REL once din_ack=0 and rq_din_valid[gnt]=0. Then drop rq_din_ack[gnt].
  - If wen=1, go to IDLE (write complete). Otherwise go to RD_WAIT and clear the timer.
- RD_WAIT:
  - The timer increments each cycle.
  - When dout_valid=1: latch rdata to rq_rdata, set rq_dout_valid[gnt]=1, and go to RD_ACK.
  - If timer reaches TMO-1 without dout_valid: pulse rq_err[gnt] for 1 cycle and go to IDLE with no data returned.
- RD_ACK:
  - On rq_dout_ack[gnt]=1, set dout_ack=1.
  - Once dout_valid=0, drop rq_dout_valid[gnt].
  - Once rq_dout_ack[gnt]=0, drop dout_ack and go to IDLE.
  - The watchdog is not active in this state.
- The non-granted requester's rq_din_ack, rq_dout_valid and rq_err stay 0 throughout. Its request stays pending and is granted in the first IDLE cycle after the current transaction. No request is lost.
- Two requesters back-to-back alternate (fairness). One requester alone may be granted repeatedly.
- A requester that drops rq_din_valid before it is granted is simply not served. Once granted, its latched command is used regardless of later changes to rq_* inputs.
- busy=1 in every state except IDLE.
- The counter width is clog2(TMO). The timer saturates and never wraps.

Decomposition:
- Shared package mem_ctl_pkg holds:
  - the state enum {IDLE, REQ, REL, RD_WAIT, RD_ACK}, 3-bit encoding
  - the default TMO constant
- The round-robin pick is a natural sub-module, rr_pick2. Inputs: req[1:0], last. Outputs: gnt, any. It is purely combinational.
- The FSM, command latch and timer stay in mem_arb2.

Test Plan:
- Single write: requester 0 drives wen=1, addr=0x12, wdata=0xA5. Required response: din_valid rises 1 cycle later, addr=0x12, wdata=0xA5, wen=1. rq_din_ack[0] mirrors din_ack. busy returns to 0 after the release with no dout activity.
- Single read: requester 1 reads addr=0x34 and the memory returns 0x5C. Required response: rq_dout_valid[1]=1 with rq_rdata=0x5C. dout_ack follows rq_dout_ack[1]. rq_dout_valid[0] stays 0 throughout.
- Simultaneous requests straight after reset (both write): requester 0 is served first, then requester 1. Required response: a second simultaneous pair is again served 0 first (last=1 after the first pair), then 1. Alternation holds across 10 back-to-back pairs.
- Read timeout with TMO=8: the memory never asserts dout_valid. Required response: rq_err[gnt] pulses exactly 8 cycles after entering RD_WAIT, busy=0 the next cycle, and a pending write from the other requester is then granted.
- Reset mid-read in RD_ACK: all outputs go to 0 immediately (asynchronously). After rst is released, a tie grants requester 0.
- Late requester release: requester 0 holds rq_din_valid for 5 cycles after din_ack falls. Required response: rq_din_ack[0] stays 1 and the FSM stays in REL until requester 0 releases, with no new grant in between.

Source files
------------

// File: rtl/mem_ctl_pkg.sv
// Shared types for the memory-controller front end: arbiter state encoding and
// the default read-return watchdog limit.
package mem_ctl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    REL     = 3'd2,
    RD_WAIT = 3'd3,
    RD_ACK  = 3'd4
  } state_t;

  localparam int TMO_DEFAULT = 64;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins outright; on a tie the
// requester that was not served last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       any
);

  assign any = |req;
  assign gnt = (&req) ? ~last : req[1];

endmodule

// File: rtl/mem_arb2.sv
// Round-robin arbiter/sequencer letting two requesters share one mem_ctl_io:
// grant, latch the command, run the din handshake and, for reads, the dout one.
module mem_arb2
  import mem_ctl_pkg::*;
#(
  parameter int AW  = 8,
  parameter int DW  = 8,
  parameter int TMO = TMO_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      rq_din_valid,
  input  logic [1:0]      rq_wen,
  input  logic [2*AW-1:0] rq_addr,
  input  logic [2*DW-1:0] rq_wdata,
  output logic [1:0]      rq_din_ack,
  output logic [1:0]      rq_dout_valid,
  input  logic [1:0]      rq_dout_ack,
  output logic [DW-1:0]   rq_rdata,
  output logic [1:0]      rq_err,
  output logic            din_valid,
  output logic            wen,
  output logic [AW-1:0]   addr,
  output logic [DW-1:0]   wdata,
  input  logic            din_ack,
  input  logic            dout_valid,
  input  logic [DW-1:0]   rdata,
  output logic            dout_ack,
  output logic            busy
);

  localparam int            TW   = $clog2(TMO);
  localparam logic [TW-1:0] TMAX = TW'(TMO - 1);

  state_t        state;
  logic          last;
  logic          gnt_q;
  logic [TW-1:0] timer;
  logic          pick;
  logic          pick_any;

  rr_pick2 u_pick (
    .req  (rq_din_valid),
    .last (last),
    .gnt  (pick),
    .any  (pick_any)
  );

  // Watchdog counter holds at its limit instead of wrapping.
  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
    return (t == TMAX) ? t : t + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      last          <= 1'b1;
      gnt_q         <= 1'b0;
      timer         <= '0;
      rq_din_ack    <= '0;
      rq_dout_valid <= '0;
      rq_rdata      <= '0;
      rq_err        <= '0;
      din_valid     <= 1'b0;
      wen           <= 1'b0;
      addr          <= '0;
      wdata         <= '0;
      dout_ack      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      rq_err <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt_q     <= pick;
            last      <= pick;
            wen       <= pick ? rq_wen[1] : rq_wen[0];
            addr      <= pick ? rq_addr[2*AW-1:AW] : rq_addr[AW-1:0];
            wdata     <= pick ? rq_wdata[2*DW-1:DW] : rq_wdata[DW-1:0];
            din_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (din_ack) begin
            din_valid         <= 1'b0;
            rq_din_ack[gnt_q] <= 1'b1;
            state             <= REL;
          end
        end
        REL: begin
          // Both sides of the din handshake must have released before moving on.
          if (!din_ack && !rq_din_valid[gnt_q]) begin
            rq_din_ack <= '0;
            if (wen) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              timer <= '0;
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          timer <= sat_inc(timer);
          if (dout_valid) begin
            rq_rdata             <= rdata;
            rq_dout_valid[gnt_q] <= 1'b1;
            state                <= RD_ACK;
          end else if (timer == TMAX) begin
            rq_err[gnt_q] <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        RD_ACK: begin
          if (rq_dout_ack[gnt_q]) dout_ack <= 1'b1;
          if (!dout_valid) rq_dout_valid <= '0;
          // Finish only after the requester has raised and then dropped its ack.
          if (dout_ack && !rq_dout_ack[gnt_q]) begin
            dout_ack      <= 1'b0;
            rq_dout_valid <= '0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb2.sv
// Bench for mem_arb2: directed requester/memory traffic, a handshake-level
// reference model compared every cycle, and literal checks on key results.
module tb_mem_arb2;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int TMO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      rq_din_valid, rq_wen, rq_din_ack, rq_dout_valid, rq_dout_ack, rq_err;
  logic [2*AW-1:0] rq_addr;
  logic [2*DW-1:0] rq_wdata;
  logic [DW-1:0]   rq_rdata, wdata, rdata;
  logic [AW-1:0]   addr;
  logic            din_valid, wen, din_ack, dout_valid, dout_ack, busy;

  logic       r_valid[2];
  logic       r_wen[2];
  logic [7:0] r_addr[2];
  logic [7:0] r_wdata[2];
  logic       r_dack[2];

  assign rq_din_valid = {r_valid[1], r_valid[0]};
  assign rq_wen       = {r_wen[1], r_wen[0]};
  assign rq_addr      = {r_addr[1], r_addr[0]};
  assign rq_wdata     = {r_wdata[1], r_wdata[0]};
  assign rq_dout_ack  = {r_dack[1], r_dack[0]};

  mem_arb2 #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .rq_din_valid(rq_din_valid), .rq_wen(rq_wen), .rq_addr(rq_addr), .rq_wdata(rq_wdata),
    .rq_din_ack(rq_din_ack), .rq_dout_valid(rq_dout_valid), .rq_dout_ack(rq_dout_ack),
    .rq_rdata(rq_rdata), .rq_err(rq_err),
    .din_valid(din_valid), .wen(wen), .addr(addr), .wdata(wdata), .din_ack(din_ack),
    .dout_valid(dout_valid), .rdata(rdata), .dout_ack(dout_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  function automatic logic probe(input int sel, input int i);
    case (sel)
      0:       return rq_din_ack[i];
      1:       return rq_dout_valid[i];
      default: return din_ack;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int i, input logic val, input string nm);
    int n = 0;
    while (probe(sel, i) !== val && n < 300) begin
      tick();
      n++;
    end
    if (probe(sel, i) !== val) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_%s: got %b, required %b", nm, probe(sel, i), val);
    end
  endtask

  function automatic logic [33:0] outs();
    return {rq_din_ack, rq_dout_valid, rq_rdata, rq_err, din_valid, wen, addr, wdata, dout_ack, busy};
  endfunction

  // Memory side: din_ack mirrors din_valid one cycle late; reads answer after mem_delay.
  logic       mem_silent = 1'b0;
  logic [7:0] mem_data = 8'h00;
  int         mem_delay = 2;
  logic       rd_pending;
  int         dly;

  initial begin
    din_ack = 0; dout_valid = 0; rdata = 0; rd_pending = 0; dly = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        din_ack = 0; dout_valid = 0; rd_pending = 0;
      end else begin
        if (din_valid && !din_ack && !wen && !mem_silent) begin
          rd_pending = 1; dly = mem_delay;
        end
        din_ack = din_valid;
        if (dout_valid && dout_ack) begin
          dout_valid = 0; rd_pending = 0;
        end else if (rd_pending && !din_valid && !din_ack && !dout_valid) begin
          if (dly > 0) dly--;
          else begin dout_valid = 1; rdata = mem_data; end
        end
      end
    end
  end

  // Reference model: phase 0 idle, 1 command offered, 2 command release,
  // 3 awaiting read data, 4 returning read data.
  logic [1:0] e_rda, e_rdv, e_err;
  logic [7:0] e_rdata, e_addr, e_wdata;
  logic       e_dv, e_wen, e_dack, e_busy, m_last, prev_dack;
  int         m_ph, m_own, m_wait;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        e_rda = 0; e_rdv = 0; e_err = 0; e_rdata = 0; e_addr = 0; e_wdata = 0;
        e_dv = 0; e_wen = 0; e_dack = 0; e_busy = 0; m_last = 1; m_ph = 0; m_own = 0; m_wait = 0;
      end
      check("cycle", 64'(outs()),
            64'({e_rda, e_rdv, e_rdata, e_err, e_dv, e_wen, e_addr, e_wdata, e_dack, e_busy}));
      if (rst) begin
        e_err = 0;
        case (m_ph)
          0: if (rq_din_valid != 2'b00) begin
            if (rq_din_valid == 2'b11) m_own = m_last ? 0 : 1;
            else m_own = rq_din_valid[1] ? 1 : 0;
            m_last = m_own[0];
            e_wen = rq_wen[m_own]; e_addr = rq_addr[m_own*8 +: 8]; e_wdata = rq_wdata[m_own*8 +: 8];
            e_dv = 1; e_busy = 1; m_ph = 1;
          end
          1: if (din_ack) begin e_dv = 0; e_rda[m_own] = 1; m_ph = 2; end
          2: if (!din_ack && !rq_din_valid[m_own]) begin
            e_rda = 0;
            if (e_wen) begin m_ph = 0; e_busy = 0; end
            else begin m_ph = 3; m_wait = 0; end
          end
          3: if (dout_valid) begin
            e_rdata = rdata; e_rdv[m_own] = 1; m_ph = 4;
          end else if (m_wait == TMO - 1) begin
            e_err[m_own] = 1; e_busy = 0; m_ph = 0;
          end else m_wait++;
          default: begin
            prev_dack = e_dack;
            if (rq_dout_ack[m_own]) e_dack = 1;
            if (!dout_valid) e_rdv = 0;
            if (prev_dack && !rq_dout_ack[m_own]) begin
              e_dack = 0; e_rdv = 0; e_busy = 0; m_ph = 0;
            end
          end
        endcase
      end
    end
  end

  // Grant log: address presented at each rising din_valid.
  logic [7:0] glog[$];
  logic       dv_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst && din_valid && !dv_prev) glog.push_back(addr);
      dv_prev = rst ? din_valid : 1'b0;
    end
  end

  task automatic finish_req(input int i, input logic w, input int hold,
                            output logic [7:0] rd, output logic er, output int n);
    rd = 0; er = 0; n = 0;
    wait_for(0, i, 1'b1, "rq_din_ack_rise");
    // Scramble the request after it is taken; the latched command must not change.
    r_wen[i] = ~r_wen[i]; r_addr[i] = ~r_addr[i]; r_wdata[i] = ~r_wdata[i];
    wait_for(3, 0, 1'b0, "din_ack_fall");
    for (int h = 0; h < hold; h++) begin
      tick();
      check("rel_hold_ack", 64'(rq_din_ack[i]), 64'd1);
      check("rel_hold_no_grant", 64'(din_valid), 64'd0);
    end
    r_valid[i] = 0;
    wait_for(0, i, 1'b0, "rq_din_ack_fall");
    if (!w) begin
      while (!rq_err[i] && !rq_dout_valid[i] && n < 200) begin
        tick();
        n++;
      end
      if (rq_err[i]) begin
        er = 1;
        check("err_busy", 64'(busy), 64'd0);
      end else if (rq_dout_valid[i]) begin
        rd = rq_rdata;
        r_dack[i] = 1;
        wait_for(1, i, 1'b0, "rq_dout_valid_fall");
        r_dack[i] = 0;
      end else begin
        vectors++; miscompares++;
        $display("FAIL wait_read_return: got no data or err, required one of them");
      end
    end
  endtask

  task automatic do_req(input int i, input logic w, input logic [7:0] a, input logic [7:0] d,
                        input int hold, output logic [7:0] rd, output logic er, output int n);
    r_wen[i] = w; r_addr[i] = a; r_wdata[i] = d; r_valid[i] = 1;
    finish_req(i, w, hold, rd, er, n);
  endtask

  logic [7:0] rd0, rd1;
  logic       er0, er1;
  int         n0, n1;

  initial begin
    for (int i = 0; i < 2; i++) begin
      r_valid[i] = 0; r_wen[i] = 0; r_addr[i] = 0; r_wdata[i] = 0; r_dack[i] = 0;
    end
    rst = 0;
    repeat (3) tick();
    check("reset_outputs", 64'(outs()), 64'd0);
    rst = 1;
    tick();

    // Single write from requester 0
    r_wen[0] = 1; r_addr[0] = 8'h12; r_wdata[0] = 8'hA5; r_valid[0] = 1;
    tick();
    check("wr_din_valid_latency", 64'(din_valid), 64'd1);
    check("wr_cmd", 64'({wen, addr, wdata}), 64'h1_12_A5);
    finish_req(0, 1'b1, 0, rd0, er0, n0);
    check("wr_busy_done", 64'(busy), 64'd0);
    check("wr_no_dout", 64'({dout_ack, rq_dout_valid}), 64'd0);
    tick();

    // Single read from requester 1
    mem_data = 8'h5C;
    do_req(1, 1'b0, 8'h34, 8'h00, 0, rd1, er1, n1);
    check("rd_data", 64'(rd1), 64'h5C);
    check("rd_no_err", 64'(er1), 64'd0);
    tick();

    // Ten simultaneous write pairs
    glog.delete();
    for (int k = 0; k < 10; k++) begin
      fork
        do_req(0, 1'b1, 8'(8'h40 + k), 8'(k), 0, rd0, er0, n0);
        do_req(1, 1'b1, 8'(8'h80 + k), 8'(k), 0, rd1, er1, n1);
      join
      tick();
    end
    check("pairs_grants", 64'(glog.size()), 64'd20);
    for (int k = 0; k < 10; k++) begin
      check("pair_first_req0", 64'(glog[2*k]), 64'(8'h40 + k));
      check("pair_second_req1", 64'(glog[2*k+1]), 64'(8'h80 + k));
    end

    // Read watchdog with a pending write from the other requester
    mem_silent = 1;
    glog.delete();
    fork
      do_req(0, 1'b0, 8'h55, 8'h00, 0, rd0, er0, n0);
      begin
        repeat (3) tick();
        do_req(1, 1'b1, 8'h66, 8'h99, 0, rd1, er1, n1);
      end
    join
    mem_silent = 0;
    check("tmo_err", 64'(er0), 64'd1);
    check("tmo_cycles", 64'(n0), 64'd8);
    check("tmo_then_req1", 64'({glog[0], glog[1]}), 64'h5566);
    tick();

    // Late release of requester 0 with requester 1 waiting
    glog.delete();
    fork
      do_req(0, 1'b1, 8'h21, 8'h3C, 5, rd0, er0, n0);
      begin
        repeat (2) tick();
        do_req(1, 1'b1, 8'h22, 8'hC3, 0, rd1, er1, n1);
      end
    join
    check("late_rel_order", 64'({glog[0], glog[1]}), 64'h2122);
    tick();

    // Asynchronous reset while requester 0's read is in its return phase
    mem_data = 8'hE1;
    r_wen[0] = 0; r_addr[0] = 8'h77; r_valid[0] = 1;
    wait_for(0, 0, 1'b1, "mid_rd_ack");
    r_valid[0] = 0;
    wait_for(1, 0, 1'b1, "mid_rd_dout_valid");
    check("mid_rd_busy", 64'(busy), 64'd1);
    #1 rst = 0;
    #1 check("async_reset_outputs", 64'(outs()), 64'd0);
    for (int i = 0; i < 2; i++) begin
      r_valid[i] = 0; r_dack[i] = 0;
    end
    repeat (2) tick();
    rst = 1;
    tick();
    glog.delete();
    fork
      do_req(0, 1'b1, 8'hA0, 8'h01, 0, rd0, er0, n0);
      do_req(1, 1'b1, 8'hB0, 8'h02, 0, rd1, er1, n1);
    join
    check("post_reset_tie", 64'({glog[0], glog[1]}), 64'hA0B0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at %0t, required to finish earlier", $time);
    $fatal(1, "bench timeout");
  end

endmodule
